// File: rtl/bsn_pkg.sv
// bsn_pkg: shared sizes, loader state and pad helper for the BSN frame loader
package bsn_pkg;
    localparam int DATA_WIDTH   = 32;
    localparam int N_INPUTS     = 8;
    localparam int SORT_LATENCY = 6;
    localparam int COUNT_W      = $clog2(N_INPUTS + 1);
    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
    // pad bit replicated across a word: ones sort last ascending, zeros sort last descending
    function automatic logic pad_bit(input logic dir);
        return ~dir;
    endfunction
endpackage

// File: rtl/bsn_frame_packer.sv
// bsn_frame_packer: slot buffer, write pointer, padding and real-word count for one frame
module bsn_frame_packer
    import bsn_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int N  = N_INPUTS,
    parameter int CW = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_wr,
    input  logic            i_last,
    input  logic            i_dir,
    input  logic            i_clr,
    input  logic [DW-1:0]   i_data,
    output logic [DW*N-1:0] o_frame,
    output logic [CW-1:0]   o_count,
    output logic            o_dir,
    output logic            o_done,
    output logic            o_busy
);
    localparam int PW = $clog2(N);
    logic [DW-1:0] r_slot [N];
    logic [CW-1:0] r_ptr;
    logic          r_dir;
    logic          r_done;
    logic          w_fin;
    assign w_fin   = i_wr && (i_last || r_ptr == CW'(N - 1));
    assign o_done  = r_done || w_fin;
    assign o_count = r_ptr + CW'(i_wr);
    assign o_busy  = o_count != '0;
    assign o_dir   = (i_wr && r_ptr == '0) ? i_dir : r_dir;
    // the frame view includes the beat in flight so the top can launch on the completing edge
    always_comb
        for (int k = 0; k < N; k++)
            o_frame[(N-1-k)*DW +: DW] = k >= int'(o_count) ? {DW{pad_bit(o_dir)}} :
                                        (i_wr && k == int'(r_ptr)) ? i_data : r_slot[k];
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_slot <= '{default: '0};
            r_ptr  <= '0;
            r_dir  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (i_wr)
                r_slot[r_ptr[PW-1:0]] <= i_data;
            if (i_wr && r_ptr == '0)
                r_dir <= i_dir;
            if (i_clr) begin
                r_ptr  <= '0;
                r_done <= 1'b0;
            end else if (i_wr) begin
                r_ptr  <= r_ptr + 1'b1;
                r_done <= w_fin;
            end
        end
endmodule

// File: rtl/bsn_frame_loader.sv
// bsn_frame_loader: packs a valid/ready word stream into frames and drives the BSN for its latency
// BSN_LOADER_OVERLAP_EN: a second packer fills the next frame while the current one sorts
module bsn_frame_loader #(
    parameter int DATA_WIDTH   = bsn_pkg::DATA_WIDTH,
    parameter int N_INPUTS     = bsn_pkg::N_INPUTS,
    parameter int SORT_LATENCY = bsn_pkg::SORT_LATENCY
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_WIDTH-1:0]          s_data,
    input  logic                           s_last,
    input  logic                           s_dir,
    output logic [DATA_WIDTH*N_INPUTS-1:0] bsn_data_in,
    output logic                           bsn_direction,
    output logic                           bsn_en,
    output logic                           bsn_launch,
    output logic                           result_valid,
    output logic [$clog2(N_INPUTS+1)-1:0]  valid_count,
    output logic                           busy
);
    import bsn_pkg::*;
    localparam int CW = $clog2(N_INPUTS + 1);
    localparam int TW = $clog2(SORT_LATENCY + 1);
`ifdef BSN_LOADER_OVERLAP_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [TW-1:0]                  r_cnt;
    logic                           r_wsel;
    logic                           r_rv;
    logic                           r_ready;
    logic                           r_launch;
    logic                           r_dir;
    logic [DATA_WIDTH*N_INPUTS-1:0] r_frame;
    logic [CW-1:0]                  r_count;
    logic [DATA_WIDTH*N_INPUTS-1:0] w_frame [NB];
    logic [CW-1:0]                  w_count [NB];
    logic [NB-1:0]                  w_dir, w_done, w_busy, w_wr, w_clr;
    logic                           w_beat, w_src, w_launch, w_ready_nxt;
    assign w_beat = s_valid && r_ready;
`ifdef BSN_LOADER_OVERLAP_EN
    // a completed frame parked in the idle packer launches before the one being filled
    assign w_src       = w_done[~r_wsel] ? ~r_wsel : r_wsel;
    assign w_ready_nxt = ~|(w_done & ~w_clr);
`else
    assign w_src       = 1'b0;
    assign w_ready_nxt = w_state_nxt != HOLD;
`endif
    assign w_launch    = w_done[w_src] && (r_state != HOLD || r_rv);
    assign w_state_nxt = w_launch ? HOLD : (r_state == HOLD && !r_rv) ? HOLD :
                         |(w_busy & ~w_clr) ? FILL : IDLE;
    for (genvar g = 0; g < NB; g++) begin : g_pk
        assign w_wr[g]  = w_beat && r_wsel == 1'(g);
        assign w_clr[g] = w_launch && w_src == 1'(g);
        bsn_frame_packer #(.DW(DATA_WIDTH), .N(N_INPUTS), .CW(CW)) u_pk (
            .clk    (clk),
            .rst    (rst),
            .i_wr   (w_wr[g]),
            .i_last (s_last),
            .i_dir  (s_dir),
            .i_clr  (w_clr[g]),
            .i_data (s_data),
            .o_frame(w_frame[g]),
            .o_count(w_count[g]),
            .o_dir  (w_dir[g]),
            .o_done (w_done[g]),
            .o_busy (w_busy[g])
        );
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_wsel   <= 1'b0;
            r_rv     <= 1'b0;
            r_ready  <= 1'b0;
            r_launch <= 1'b0;
            r_frame  <= '0;
            r_count  <= '0;
            r_dir    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ready  <= w_ready_nxt;
            r_launch <= w_launch;
            // counter reaches zero SORT_LATENCY-1 cycles in; the pulse follows on the next edge
            r_rv     <= !w_launch && r_state == HOLD && r_cnt == '0 && !r_rv;
            r_cnt    <= w_launch ? TW'(SORT_LATENCY - 1) : r_cnt - TW'(r_cnt != '0);
            if (NB == 2 && w_beat && |(w_done & w_wr))
                r_wsel <= ~r_wsel;
            if (w_launch) begin
                r_frame <= w_frame[w_src];
                r_count <= w_count[w_src];
                r_dir   <= w_dir[w_src];
            end
        end
    assign s_ready       = r_ready;
    assign bsn_data_in   = r_frame;
    assign bsn_direction = r_dir;
    assign valid_count   = r_count;
    assign bsn_launch    = r_launch;
    assign result_valid  = r_rv;
    assign bsn_en        = r_state == HOLD;
    assign busy          = r_state == HOLD;
endmodule

// File: tb/tb_bsn_frame_loader.sv
// tb_bsn_frame_loader: directed and randomized frames against a queue-based frame model
module tb_bsn_frame_loader;
    localparam int DW = 32;
    localparam int N = 8;
    localparam int LAT = 6;
    localparam int CW = $clog2(N + 1);
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic s_dir = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic s_ready, bsn_direction, bsn_en, bsn_launch, result_valid, busy;
    logic [DW*N-1:0] bsn_data_in;
    logic [CW-1:0] valid_count;
    logic [DW-1:0] q[$];
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    bsn_frame_loader dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .s_dir(s_dir), .bsn_data_in(bsn_data_in), .bsn_direction(bsn_direction),
        .bsn_en(bsn_en), .bsn_launch(bsn_launch), .result_valid(result_valid),
        .valid_count(valid_count), .busy(busy)
    );
    task automatic check(input string tag, input logic [DW*N-1:0] obs, input logic [DW*N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // expected frame: words in arrival order from the top slot down, then pad words
    function automatic logic [DW*N-1:0] model(input logic [DW-1:0] w[$], input logic dir);
        logic [DW*N-1:0] f = '0;
        for (int k = 0; k < N; k++)
            f = {f[DW*(N-1)-1:0], (k < w.size()) ? w[k] : (dir ? {DW{1'b0}} : {DW{1'b1}})};
        return f;
    endfunction
    task automatic check_reset(input string tag);
        check({tag, "_ready"}, s_ready, 0);
        check({tag, "_data"}, bsn_data_in, 0);
        check({tag, "_dir"}, bsn_direction, 0);
        check({tag, "_en"}, bsn_en, 0);
        check({tag, "_launch"}, bsn_launch, 0);
        check({tag, "_rv"}, result_valid, 0);
        check({tag, "_count"}, valid_count, 0);
        check({tag, "_busy"}, busy, 0);
    endtask
    task automatic run_frame(input logic [DW-1:0] w[$], input logic dir, input bit gaps,
                             input bit last_full, input int abort_at);
        logic [DW*N-1:0] exp_f;
        int i = 0;
        int budget = 0;
        bit beat;
        exp_f = model(w, dir);
        while (i < w.size()) begin
            check("ready_fill", s_ready, 1);
            s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data = s_valid ? w[i] : $urandom;
            s_dir = (i == 0) ? dir : 1'($urandom);
            s_last = (i == w.size() - 1) && (w.size() < N || last_full);
            beat = s_valid && s_ready;
            step();
            if (beat) i++;
            if (i < w.size()) check("no_early_launch", bsn_launch, 0);
            if (++budget > 100) begin
                checks++;
                failures++;
                $error("FAIL fill_timeout: observed %0d beats expected %0d", i, w.size());
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b1;
        s_data = $urandom;
        s_last = 1'($urandom);
        check("launch", bsn_launch, 1);
        check("frame", bsn_data_in, exp_f);
        check("count", valid_count, w.size());
        check("direction", bsn_direction, dir);
        check("en_launch", bsn_en, 1);
        check("busy_launch", busy, 1);
        check("ready_launch", s_ready, 0);
        check("rv_launch", result_valid, 0);
        for (int c = 1; c <= LAT; c++) begin
            step();
            check("rv_timing", result_valid, c == LAT);
            check("launch_once", bsn_launch, 0);
            check("en_hold", bsn_en, 1);
            check("ready_hold", s_ready, 0);
            check("frame_hold", bsn_data_in, exp_f);
            if (c == abort_at) begin
                rst = 1'b0;
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        step();
        check("en_after", bsn_en, 0);
        check("rv_after", result_valid, 0);
        check("ready_after", s_ready, 1);
        check("frame_after", bsn_data_in, exp_f);
        check("count_after", valid_count, w.size());
    endtask
    initial begin
        step();
        step();
        check_reset("por");
        rst = 1'b1;
        step();
        check("ready_release", s_ready, 1);
        check("en_release", bsn_en, 0);
        s_valid = 1'b1;
        s_dir = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_data = $urandom;
            step();
        end
        s_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_reset("fill_rst");
        step();
        check("rv_in_reset", result_valid, 0);
        rst = 1'b1;
        step();
        check("ready_release2", s_ready, 1);
        q = '{32'd5, 32'd7, 32'd4, 32'd1, 32'd0, 32'd6, 32'd3, 32'd2};
        run_frame(q, 1'b0, 1'b0, 1'b1, 0);
        q = '{32'd9, 32'd3, 32'd5};
        run_frame(q, 1'b0, 1'b0, 1'b1, 0);
        run_frame(q, 1'b1, 1'b0, 1'b1, 0);
        q.delete();
        for (int k = 0; k < N; k++) q.push_back($urandom);
        run_frame(q, 1'b1, 1'b1, 1'b0, 0);
        q = '{32'd100, 32'd200, 32'd300, 32'd400};
        run_frame(q, 1'b0, 1'b0, 1'b1, 3);
        #1;
        check_reset("hold_rst");
        step();
        step();
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check("no_rv_after_abort", result_valid, 0);
            check("no_launch_after_abort", bsn_launch, 0);
        end
        q = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd55};
        run_frame(q, 1'b1, 1'b1, 1'b1, 0);
        for (int f = 0; f < 12; f++) begin
            q.delete();
            for (int k = $urandom_range(1, N); k > 0; k--) q.push_back($urandom);
            run_frame(q, 1'($urandom), 1'($urandom), 1'($urandom), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
